// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared definitions for the VC weighted round-robin scheduler.
// Holds the scheduler state encoding and the power-on burst weights,
// so the top level and any future bench helpers agree on them.
package vc_wrr_scheduler_pkg;

  localparam int CNT_W_DEF        = 4;
  localparam int W0_DEF           = 3;
  localparam int W1_DEF           = 1;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRV0 = 2'd1,
    SRV1 = 2'd2
  } wrr_state_e;

endpackage

// File: rtl/wrr_burst_counter.sv
// Burst length counter for the VC weighted round-robin scheduler.
// Counts pops inside the current burst and flags the pop that ends it.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high reset (count returns to 0)
//   clear    - synchronous clear, starts a new burst (wins over inc)
//   inc      - count one pop; with neither clear nor inc the count holds
//   weight   - burst weight of the VC being served (0 behaves as 1)
//   terminal - high when the current count is the last slot of the burst
module wrr_burst_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] weight,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] eff_weight;

  // A zero weight would otherwise lock a VC out entirely, so it is promoted
  // to a single-pop burst; the terminal slot is then weight-1.
  always_comb begin
    eff_weight = (weight == '0) ? ONE : weight;
    terminal   = (burst_cnt == (eff_weight - ONE));
  end

  // Burst counter register: clear beats increment, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (clear) begin
      burst_cnt <= '0;
    end else if (inc) begin
      burst_cnt <= burst_cnt + ONE;
    end
  end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin pop scheduler for the two virtual-channel FIFOs.
// VC0 and VC1 are served in bursts of configurable length; the weights are
// loaded while init is high. Downstream pauses and init suspend all pops.
// A starvation flag warns the control FSM when VC1 waits too long.
//
// Ports:
//   clk, reset             - clock and asynchronous active-high reset
//   init                   - config window: load weights, no scheduling
//   weight_vc0, weight_vc1 - burst weights, sampled while init is high
//   empty_vc0, empty_vc1   - source FIFO empty flags
//   pausa_d0, pausa_d1     - destination FIFO pause (almost-full)
//   pop_vc0, pop_vc1       - pop strobes, same cycle as the inputs
//   sel_vc1                - current owner (0 = VC0, 1 = VC1), registered
//   starve_vc1             - VC1 starvation flag, registered
module vc_wrr_scheduler #(
  parameter int CNT_W        = vc_wrr_scheduler_pkg::CNT_W_DEF,
  parameter int W0_DEF       = vc_wrr_scheduler_pkg::W0_DEF,
  parameter int W1_DEF       = vc_wrr_scheduler_pkg::W1_DEF,
  parameter int STARVE_LIMIT = vc_wrr_scheduler_pkg::STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [CNT_W-1:0] weight_vc0,
  input  logic [CNT_W-1:0] weight_vc1,
  input  logic             empty_vc0,
  input  logic             empty_vc1,
  input  logic             pausa_d0,
  input  logic             pausa_d1,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             sel_vc1,
  output logic             starve_vc1
);

  import vc_wrr_scheduler_pkg::*;

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  wrr_state_e       state;
  wrr_state_e       state_nxt;
  logic [CNT_W-1:0] wgt0_q;
  logic [CNT_W-1:0] wgt1_q;
  logic [CNT_W-1:0] cur_wgt;
  logic [SC_W-1:0]  starve_cnt;
  logic [SC_W-1:0]  starve_cnt_nxt;
  logic             blocked;
  logic             burst_term;
  logic             burst_done;
  logic             cnt_clear;
  logic             cnt_inc;

  // Pops are decoded straight from the registered owner so the FIFOs can
  // sample them on the same edge; only one owner exists, so they never
  // both fire.
  always_comb begin
    blocked = init | pausa_d0 | pausa_d1;
    pop_vc0 = (state == SRV0) & ~empty_vc0 & ~blocked;
    pop_vc1 = (state == SRV1) & ~empty_vc1 & ~blocked;
    cur_wgt = (state == SRV1) ? wgt1_q : wgt0_q;
  end

  wrr_burst_counter #(
    .CNT_W (CNT_W)
  ) u_burst_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .weight   (cur_wgt),
    .terminal (burst_term)
  );

  // Next-state logic. A burst ends on its last pop or as soon as the owner
  // runs dry; the other VC then gets the channel if it has data, otherwise
  // the same VC starts a fresh burst, otherwise the scheduler idles.
  // init forces IDLE; a pause freezes both state and burst count.
  always_comb begin
    state_nxt  = state;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    burst_done = 1'b0;
    if (init) begin
      state_nxt = IDLE;
      cnt_clear = 1'b1;
    end else if (!blocked) begin
      case (state)
        IDLE: begin
          cnt_clear = 1'b1;
          if (!empty_vc0) begin
            state_nxt = SRV0;
          end else if (!empty_vc1) begin
            state_nxt = SRV1;
          end
        end
        SRV0: begin
          burst_done = (pop_vc0 & burst_term) | empty_vc0;
          if (burst_done) begin
            cnt_clear = 1'b1;
            if (!empty_vc1) begin
              state_nxt = SRV1;
            end else if (!empty_vc0) begin
              state_nxt = SRV0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_inc = pop_vc0;
          end
        end
        SRV1: begin
          burst_done = (pop_vc1 & burst_term) | empty_vc1;
          if (burst_done) begin
            cnt_clear = 1'b1;
            if (!empty_vc0) begin
              state_nxt = SRV0;
            end else if (!empty_vc1) begin
              state_nxt = SRV1;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_inc = pop_vc1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  // Starvation counting: VC1 waiting with data and not being popped adds
  // one, saturating at the limit. Being served or having nothing to send
  // clears it; any blocking condition freezes it.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!blocked) begin
      if (pop_vc1 | empty_vc1) begin
        starve_cnt_nxt = '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt_nxt = starve_cnt + SC_W'(1);
      end
    end
  end

  // FSM state register, plus the owner indication registered alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel_vc1 <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_vc1 <= (state_nxt == SRV1);
    end
  end

  // Weight registers follow the inputs for the whole init window, so the
  // values seen on its last cycle are the ones kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wgt0_q <= CNT_W'(W0_DEF);
      wgt1_q <= CNT_W'(W1_DEF);
    end else if (init) begin
      wgt0_q <= weight_vc0;
      wgt1_q <= weight_vc1;
    end
  end

  // Starvation counter and its registered flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve_vc1 <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      starve_vc1 <= (starve_cnt_nxt == STARVE_MAX);
    end
  end

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: directed scenarios followed by randomized
// traffic. A behavioural model of the two source FIFOs and the weighted
// round-robin policy predicts each cycle's outputs into a queue; a
// separate monitor pops and compares on the falling edge.
module tb_vc_wrr_scheduler;

  localparam int CNT_W        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int DEF_W0       = 3;
  localparam int DEF_W1       = 1;

  logic             clk;
  logic             reset;
  logic             init;
  logic [CNT_W-1:0] weight_vc0;
  logic [CNT_W-1:0] weight_vc1;
  logic             empty_vc0;
  logic             empty_vc1;
  logic             pausa_d0;
  logic             pausa_d1;
  logic             pop_vc0;
  logic             pop_vc1;
  logic             sel_vc1;
  logic             starve_vc1;

  vc_wrr_scheduler #(
    .CNT_W        (CNT_W),
    .W0_DEF       (DEF_W0),
    .W1_DEF       (DEF_W1),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .init       (init),
    .weight_vc0 (weight_vc0),
    .weight_vc1 (weight_vc1),
    .empty_vc0  (empty_vc0),
    .empty_vc1  (empty_vc1),
    .pausa_d0   (pausa_d0),
    .pausa_d1   (pausa_d1),
    .pop_vc0    (pop_vc0),
    .pop_vc1    (pop_vc1),
    .sel_vc1    (sel_vc1),
    .starve_vc1 (starve_vc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected {pop_vc0, pop_vc1, sel_vc1, starve_vc1}
  logic [3:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Model state: owner -1 = nobody, 0 = VC0, 1 = VC1
  int m_owner;
  int m_served;
  int m_w0;
  int m_w1;
  int m_waiting;
  int q0;
  int q1;

  task automatic modelReset();
    m_owner   = -1;
    m_served  = 0;
    m_w0      = DEF_W0;
    m_w1      = DEF_W1;
    m_waiting = 0;
  endtask

  task automatic modelStep(input bit ini, input int wv0, input int wv1,
                           input bit p0, input bit p1);
    bit blocked, e0, e1, pop0, pop1, mine_empty, other_empty, popped, finished;
    int lim;
    blocked = ini || p0 || p1;
    e0      = (q0 == 0);
    e1      = (q1 == 0);
    pop0    = (m_owner == 0) && !e0 && !blocked;
    pop1    = (m_owner == 1) && !e1 && !blocked;
    exp_q.push_back({pop0, pop1, (m_owner == 1), (m_waiting >= STARVE_LIMIT)});
    if (!blocked) begin
      if (pop1 || e1) m_waiting = 0;
      else            m_waiting++;
    end
    if (ini) begin
      m_w0     = wv0;
      m_w1     = wv1;
      m_owner  = -1;
      m_served = 0;
    end else if (!blocked) begin
      if (m_owner == -1) begin
        m_served = 0;
        if (!e0)      m_owner = 0;
        else if (!e1) m_owner = 1;
      end else begin
        mine_empty  = (m_owner == 0) ? e0 : e1;
        other_empty = (m_owner == 0) ? e1 : e0;
        popped      = (m_owner == 0) ? pop0 : pop1;
        lim         = (m_owner == 0) ? m_w0 : m_w1;
        if (lim == 0) lim = 1;
        if (popped) m_served++;
        finished = mine_empty || (popped && m_served == lim);
        if (finished) begin
          m_served = 0;
          if (!other_empty)     m_owner = 1 - m_owner;
          else if (!mine_empty) m_owner = m_owner;
          else                  m_owner = -1;
        end
      end
    end
    if (pop0) q0--;
    if (pop1) q1--;
  endtask

  // Drive one clock cycle of inputs just after the rising edge and record
  // what the model expects the DUT to show during that cycle.
  task automatic applyStimulus(input bit rst, input bit ini,
                               input int wv0, input int wv1,
                               input bit p0, input bit p1,
                               input int add0, input int add1);
    @(posedge clk);
    #1;
    q0 += add0;
    q1 += add1;
    reset      = rst;
    init       = ini;
    weight_vc0 = CNT_W'(wv0);
    weight_vc1 = CNT_W'(wv1);
    pausa_d0   = p0;
    pausa_d1   = p1;
    empty_vc0  = (q0 == 0);
    empty_vc1  = (q1 == 0);
    if (rst) begin
      modelReset();
      exp_q.push_back(4'b0000);
    end else begin
      modelStep(ini, wv0, wv1, p0, p1);
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit p0, input bit p1);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, p0, p1, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q0 == 0 && q1 == 0 && m_owner == -1) break;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic checkOutput(input logic [3:0] expv);
    logic [3:0] act;
    act = {pop_vc0, pop_vc1, sel_vc1, starve_vc1};
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL outputs cycle %0d {pop0,pop1,sel,starve}: got %b expected %b",
               cyc, act, expv);
    end
  endtask

  // Monitor: compares whatever the stimulus side predicted for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    reset = 1'b1; init = 1'b0; weight_vc0 = '0; weight_vc1 = '0;
    pausa_d0 = 1'b0; pausa_d1 = 1'b0; empty_vc0 = 1'b1; empty_vc1 = 1'b1;
    q0 = 0; q1 = 0;
    modelReset();

    $display("[TB] reset with both VCs loaded, default 3:1 weights");
    applyStimulus(1, 0, 0, 0, 0, 0, 20, 20);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    run(13, 0, 0);
    drain();

    $display("[TB] init weights 2/2, four words each");
    applyStimulus(0, 1, 2, 2, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 2, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 4);
    run(10, 0, 0);
    drain();

    $display("[TB] pause mid-burst with weights 3/1");
    applyStimulus(0, 1, 3, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 2);
    run(2, 0, 0);
    run(4, 0, 1);
    run(6, 0, 0);
    drain();

    $display("[TB] VC0 alone with seven words");
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    run(10, 0, 0);
    drain();

    $display("[TB] weights 15/1, VC1 starvation");
    applyStimulus(0, 1, 15, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 30, 3);
    run(24, 0, 0);
    drain();

    $display("[TB] asynchronous reset while VC1 is served");
    applyStimulus(0, 1, 1, 4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2, 10);
    for (int i = 0; i < 20; i++) begin
      if (m_owner == 1 && q1 > 1) break;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 4, 0);
    run(12, 0, 0);
    drain();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 149) == 0),
                    ($urandom_range(0, 39) == 0),
                    $urandom_range(0, 15), $urandom_range(0, 15),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 2) == 0) ? 1 : 0,
                    ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #2;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
